// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen: parametrised video timing with registered test-pattern RGB output.
// Pattern and solid colour are sampled at the top of each frame so that switching modes never tears.
module video_timing_pattern_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   BPC      = 8,
  parameter int   CNT_W    = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [1:0]       pattern_sel,
  input  logic [3*BPC-1:0] solid_rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [BPC-1:0]   red,
  output logic [BPC-1:0]   green,
  output logic [BPC-1:0]   blue,
  output logic             frame_start,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt
);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(H_ACTIVE / 8 - 1);
  logic [CNT_W-1:0] r_h, r_v, r_bpx;
  logic [2:0]       r_bar;
  logic [1:0]       r_pat;
  logic [3*BPC-1:0] r_solid;
  logic             w_first, w_hwrap, w_bstep, w_de, w_hs, w_vs;
  logic [1:0]       w_pat;
  logic [3*BPC-1:0] w_solid, w_bars, w_rgb;
  assign w_first = (r_h == '0) && (r_v == '0);
  assign w_hwrap = r_h == H_LAST;
  // Bar 7 never advances, so it absorbs the remainder pixels and all of blanking.
  assign w_bstep = (r_bpx == W_LAST) && (r_bar != 3'd7);
  assign w_pat   = w_first ? pattern_sel : r_pat;
  assign w_solid = w_first ? solid_rgb : r_solid;
  assign w_de    = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs    = (r_h >= HS_BEG && r_h < HS_END) ? HS_POL : ~HS_POL;
  assign w_vs    = (r_v >= VS_BEG && r_v < VS_END) ? VS_POL : ~VS_POL;
  assign w_bars  = {{BPC{~r_bar[1]}}, {BPC{~r_bar[2]}}, {BPC{~r_bar[0]}}};
  assign w_rgb   = !w_de          ? '0 :
                   w_pat == 2'd0  ? w_bars :
                   w_pat == 2'd1  ? {3{r_h[BPC-1:0]}} :
                   w_pat == 2'd2  ? ((r_h[5] ^ r_v[5]) ? '1 : '0) :
                   w_solid;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_h         <= '0;
      r_v         <= '0;
      r_bpx       <= '0;
      r_bar       <= '0;
      r_pat       <= '0;
      r_solid     <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      {red, green, blue} <= '0;
      frame_start <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
    end else if (en) begin
      r_h         <= w_hwrap ? '0 : r_h + 1'b1;
      r_v         <= !w_hwrap ? r_v : (r_v == V_LAST) ? '0 : r_v + 1'b1;
      r_bar       <= w_hwrap ? '0 : w_bstep ? r_bar + 1'b1 : r_bar;
      r_bpx       <= (w_hwrap || w_bstep) ? '0 : r_bpx + 1'b1;
      r_pat       <= w_pat;
      r_solid     <= w_solid;
      hsync       <= w_hs;
      vsync       <= w_vs;
      de          <= w_de;
      {red, green, blue} <= w_rgb;
      frame_start <= w_first;
      h_cnt       <= r_h;
      v_cnt       <= r_v;
    end
  end
endmodule

// File: doc/video_timing_pattern_gen.md
Name: video_timing_pattern_gen

Overview:
Parametrised video timing and test-pattern source feeding the DVI/HDMI encoder.
- Replaces the fixed-mode VGA pattern block; one RTL serves 720p, 1080p or custom timings via parameters.
- Adds runtime-selectable patterns, a frame-boundary-safe mode switch, and a clock-enable for pixel pacing.
- Output is a registered RGB/hsync/vsync/de stream in the pixel clock domain.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, hsync width (pixels)
H_BP, 220, horizontal back porch (pixels)
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch (lines)
HS_POL, 1, hsync active level (1 = active-high)
VS_POL, 1, vsync active level
BPC, 8, bits per colour component
CNT_W, 12, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
CLK  in  1  pixel clock
RST  in  1  asynchronous, active-high reset
en  in  1  pixel enable; counters advance only when high
pattern_sel  in  2  0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid
solid_rgb  in  3*BPC  solid colour {R,G,B}
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  data enable, high in active area
red  out  BPC  red component
green  out  BPC  green component
blue  out  BPC  blue component
frame_start  out  1  one-cycle pulse aligned with first active pixel of a frame
h_cnt  out  CNT_W  pixel index of the current output
v_cnt  out  CNT_W  line index of the current output

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
- Line layout: active [0, H_ACTIVE), then FP, SYNC, BP. Same ordering for lines.
- h counter runs 0..H_TOTAL-1 and wraps to 0. v increments when h wraps; v wraps at V_TOTAL-1 to 0.
- hsync level = HS_POL when h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HS_POL. vsync uses the same rule with v and VS_POL.
- de = (h<H_ACTIVE) && (v<V_ACTIVE).
- Latency: all outputs registered, exactly 1 en-qualified cycle after the counter state they describe. h_cnt/v_cnt outputs are delayed to match.
- Pattern and solid-colour latch: pattern_sel and solid_rgb are latched only when counters are at h=0, v=0 and en=1. Changes mid-frame take effect on the next frame, so there is no tearing.
- Pattern 0 (colour bars):
  - 8 bars, order white, yellow, cyan, green, magenta, red, blue, black.
  - Bar width W = H_ACTIVE/8 (integer). Bar index comes from a bar counter, not a divider.
  - Remainder pixels belong to bar 7.
  - Full scale = all-ones BPC.
- Pattern 1 (grey ramp): R=G=B = h[BPC-1:0]; wraps every 2^BPC pixels.
- Pattern 2 (checkerboard): 32x32 cells. White if h[5]^v[5], else black.
- Pattern 3 (solid): latched solid_rgb.
- Outside the active area, RGB = 0.
- en low: counters and all outputs hold their current values. No frame_start pulse while en is low.
- frame_start = 1 for the single output cycle where h_cnt=0, v_cnt=0.
- Reset (async assert, release synchronous to CLK):
  - counters = 0; latched pattern = 0; latched solid colour = 0.
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - de = 0, RGB = 0, frame_start = 0, h_cnt = v_cnt = 0.
- Reset mid-frame: outputs return to reset values immediately. The first frame after release starts at h=0, v=0 with frame_start on the first en cycle.

Test Plan:
1. Reset release, en=1, defaults → frame_start at 1st output cycle. de high for 1280 cycles per line. hsync high on output cycles 1391..1430 of line 0. Line period 1650, frame period 1650*750 = 1,237,500 cycles.
2. Defaults, pattern_sel=0 → line 0 pixels 0..159 = FFFFFF, 160..319 = FFFF00, ..., 1120..1279 = 000000. Blanking pixels = 000000.
3. Params H_ACTIVE=20 (W=2, remainder 4), pattern 0 → bar 7 covers pixels 14..19.
4. pattern_sel 0→2 at line 300 → bars remain until frame end. Next frame: pixel (32,0) = FFFFFF, (0,0) = 000000, (32,32) = 000000.
5. en toggled 1,0,0,1 during active video → outputs frozen for 2 cycles. Resumed pixel sequence has no skipped or repeated h_cnt values.
6. HS_POL=0, VS_POL=0; RST asserted at v=400 for 3 cycles → hsync/vsync read 1 during reset. After release, frame_start at next en cycle with h_cnt=0, v_cnt=0.
